cfg_reg_bank: RTL

Parametrised configuration register bank: the second-generation system register file between the system controller and the UART/clock-divider datapath. It adds generic depth, any number of exported registers, selectable read latency, error reporting, per-register update strobes, and an optional shadow/commit scheme. Exported words drive downstream configuration directly. Read data returns to the controller with a valid strobe.

---
 rtl/cfg_reg_pkg.sv | 35 +++
 rtl/cfg_rd_pipe.sv | 46 ++++
 rtl/cfg_reg_bank.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/cfg_reg_pkg.sv
// Shared types and constants for the configuration register bank.
// Holds the reset-value function, COMMIT location helpers and the access-type enum.
package cfg_reg_pkg;

    localparam int unsigned COMMIT_BIT = 0;

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        READ,
        ERR
    } acc_type_e;

    function automatic int unsigned commit_addr(input int unsigned depth);
        return depth - 1;
    endfunction

    // Result is wider than any legal word; callers truncate to BUS_WIDTH, which also
    // drops the upper PRESCALE bits that do not fit in word 2.
    function automatic logic [63:0] reset_word(input int unsigned addr,
                                               input int unsigned par_en,
                                               input int unsigned par_type,
                                               input int unsigned prescale,
                                               input int unsigned div_ratio);
        logic [63:0] w;
        w = '0;
        case (addr)
            2: w = (64'(prescale) << 2) | (64'(par_type & 1) << 1) | 64'(par_en & 1);
            3: w = 64'(div_ratio);
            default: w = '0;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/cfg_rd_pipe.sv
// Read-return pipeline: RD_LATENCY stages of data/valid/err with asynchronous clear.
// The output data stage only loads on a valid beat so RdData holds between reads.
module cfg_rd_pipe #(
    parameter int unsigned BUS_WIDTH  = 8,
    parameter int unsigned RD_LATENCY = 1
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 in_valid,
    input  logic                 in_err,
    input  logic [BUS_WIDTH-1:0] in_data,
    output logic                 out_valid,
    output logic                 out_err,
    output logic [BUS_WIDTH-1:0] out_data
);

    logic [RD_LATENCY-1:0][BUS_WIDTH-1:0] data_q;
    logic [RD_LATENCY-1:0]                valid_q;
    logic [RD_LATENCY-1:0]                err_q;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            data_q  <= '0;
            valid_q <= '0;
            err_q   <= '0;
        end else begin
            valid_q[0] <= in_valid;
            err_q[0]   <= in_err;
            if (in_valid) begin
                data_q[0] <= in_data;
            end
            for (int i = 1; i < RD_LATENCY; i++) begin
                valid_q[i] <= valid_q[i-1];
                err_q[i]   <= err_q[i-1];
                if (valid_q[i-1]) begin
                    data_q[i] <= data_q[i-1];
                end
            end
        end
    end

    assign out_valid = valid_q[RD_LATENCY-1];
    assign out_err   = err_q[RD_LATENCY-1];
    assign out_data  = data_q[RD_LATENCY-1];

endmodule

// File: rtl/cfg_reg_bank.sv
// Parametrised configuration register bank with exported words and update strobes.
// Define CFG_REG_SHADOW_EN to drive REG_EXPORT from shadow copies loaded by the COMMIT word.
module cfg_reg_bank
    import cfg_reg_pkg::*;
#(
    parameter int unsigned BUS_WIDTH  = 8,
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned NUM_EXPORT = 4,
    parameter int unsigned RD_LATENCY = 1,
    parameter int unsigned PAR_EN     = 1,
    parameter int unsigned PAR_TYPE   = 0,
    parameter int unsigned PRESCALE   = 32,
    parameter int unsigned DIV_RATIO  = 32
) (
    input  logic                             CLK,
    input  logic                             RST,
    input  logic                             WrEn,
    input  logic                             RdEn,
    input  logic [ADDR_WIDTH-1:0]            Address,
    input  logic [BUS_WIDTH-1:0]             WrData,
    output logic [BUS_WIDTH-1:0]             RdData,
    output logic                             RdData_Valid,
    output logic                             Err,
    output logic [NUM_EXPORT*BUS_WIDTH-1:0]  REG_EXPORT,
    output logic [NUM_EXPORT-1:0]            REG_UPDATED
);

    localparam int unsigned COMMIT_ADDR = commit_addr(DEPTH);

    logic [BUS_WIDTH-1:0] regs_q [DEPTH];
    logic [BUS_WIDTH-1:0] exp_word [NUM_EXPORT];
    logic [BUS_WIDTH-1:0] prev_q [NUM_EXPORT];
    logic [NUM_EXPORT-1:0] upd_q;
    logic [BUS_WIDTH-1:0] rd_word;
    logic                 in_range;
    logic                 wr_ok;
    logic                 err_fast_q;
    logic                 pipe_valid;
    logic                 pipe_err;
    acc_type_e            acc;

    assign in_range = {1'b0, Address} < (ADDR_WIDTH + 1)'(DEPTH);

    always_comb begin
        unique case ({WrEn, RdEn})
            2'b10:   acc = WRITE;
            2'b01:   acc = READ;
            2'b11:   acc = ERR;
            default: acc = IDLE;
        endcase
    end

    assign wr_ok = (acc == WRITE) && in_range;

    always_comb begin
        rd_word = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (in_range && Address == ADDR_WIDTH'(i)) begin
                rd_word = regs_q[i];
            end
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= BUS_WIDTH'(reset_word(i, PAR_EN, PAR_TYPE, PRESCALE, DIV_RATIO));
            end
        end else begin
`ifdef CFG_REG_SHADOW_EN
            // COMMIT self-clears one cycle after it was set; a fresh write below wins.
            if (regs_q[COMMIT_ADDR][COMMIT_BIT]) begin
                regs_q[COMMIT_ADDR][COMMIT_BIT] <= 1'b0;
            end
`endif
            for (int i = 0; i < DEPTH; i++) begin
                if (wr_ok && Address == ADDR_WIDTH'(i)) begin
                    regs_q[i] <= WrData;
                end
            end
        end
    end

`ifdef CFG_REG_SHADOW_EN
    logic [BUS_WIDTH-1:0] shadow_q [NUM_EXPORT];

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            for (int k = 0; k < NUM_EXPORT; k++) begin
                shadow_q[k] <= BUS_WIDTH'(reset_word(k, PAR_EN, PAR_TYPE, PRESCALE, DIV_RATIO));
            end
        end else if (regs_q[COMMIT_ADDR][COMMIT_BIT]) begin
            for (int k = 0; k < NUM_EXPORT; k++) begin
                shadow_q[k] <= regs_q[k];
            end
        end
    end

    always_comb begin
        for (int k = 0; k < NUM_EXPORT; k++) begin
            exp_word[k] = shadow_q[k];
        end
    end
`else
    always_comb begin
        for (int k = 0; k < NUM_EXPORT; k++) begin
            exp_word[k] = regs_q[k];
        end
    end
`endif

    // prev_q lags the export by one edge, so a change shows up as a one-cycle pulse.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            for (int k = 0; k < NUM_EXPORT; k++) begin
                prev_q[k] <= BUS_WIDTH'(reset_word(k, PAR_EN, PAR_TYPE, PRESCALE, DIV_RATIO));
            end
            upd_q <= '0;
        end else begin
            for (int k = 0; k < NUM_EXPORT; k++) begin
                prev_q[k] <= exp_word[k];
                upd_q[k]  <= (exp_word[k] != prev_q[k]);
            end
        end
    end

    // Collisions and dropped writes report after one cycle; bad reads ride the pipe.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            err_fast_q <= 1'b0;
        end else begin
            err_fast_q <= (acc == ERR) || ((acc == WRITE) && !in_range);
        end
    end

    cfg_rd_pipe #(
        .BUS_WIDTH  (BUS_WIDTH),
        .RD_LATENCY (RD_LATENCY)
    ) u_rd_pipe (
        .CLK       (CLK),
        .RST       (RST),
        .in_valid  (acc == READ),
        .in_err    ((acc == READ) && !in_range),
        .in_data   (rd_word),
        .out_valid (pipe_valid),
        .out_err   (pipe_err),
        .out_data  (RdData)
    );

    assign RdData_Valid = pipe_valid;
    assign Err          = err_fast_q | pipe_err;
    assign REG_UPDATED  = upd_q;

    for (genvar k = 0; k < NUM_EXPORT; k++) begin : g_export
        assign REG_EXPORT[k*BUS_WIDTH +: BUS_WIDTH] = exp_word[k];
    end

endmodule
